// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter for a single-outstanding data-memory port
module dmem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_r0_valid,
  input  logic        i_r1_valid,
  output logic        o_r0_ready,
  output logic        o_r1_ready,
  input  logic        i_r0_we,
  input  logic [3:0]  i_r0_sel,
  input  logic [31:0] i_r0_addr,
  input  logic [31:0] i_r0_wdata,
  input  logic        i_r1_we,
  input  logic [3:0]  i_r1_sel,
  input  logic [31:0] i_r1_addr,
  input  logic [31:0] i_r1_wdata,
  output logic        o_r0_rvalid,
  output logic [31:0] o_r0_rdata,
  output logic        o_r0_err,
  output logic        o_r1_rvalid,
  output logic [31:0] o_r1_rdata,
  output logic        o_r1_err,
  output logic        o_m_wr_en,
  output logic [3:0]  o_m_sel,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  output logic        o_m_d_ready,
  input  logic [31:0] i_m_rdata,
  input  logic        i_m_d_valid,
  input  logic        i_m_error
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic prio, gnt, l_gnt, l_we, r_err, hs, tmo, mem_on, resp;
  logic [3:0] l_sel;
  logic [31:0] l_addr, l_wdata, r_data;
  logic [7:0] cnt;
  assign gnt = (i_r0_valid && i_r1_valid) ? prio : i_r1_valid;
  assign o_r0_ready = state == IDLE && !rst && i_r0_valid && !gnt;
  assign o_r1_ready = state == IDLE && !rst && i_r1_valid && gnt;
  assign hs = o_r0_ready || o_r1_ready;
  assign tmo = cnt == 8'(TIMEOUT - 1);
  assign mem_on = state == ISSUE || state == WAIT;
  assign resp = state == RESP;
  assign o_m_wr_en = state == ISSUE && l_we;
  assign o_m_d_ready = mem_on;
  assign o_m_sel = mem_on ? l_sel : 4'h0;
  assign o_m_addr = mem_on ? l_addr : 32'h0;
  assign o_m_wdata = mem_on ? l_wdata : 32'h0;
  assign o_r0_rvalid = resp && !l_gnt;
  assign o_r1_rvalid = resp && l_gnt;
  assign o_r0_rdata = o_r0_rvalid ? r_data : 32'h0;
  assign o_r1_rdata = o_r1_rvalid ? r_data : 32'h0;
  assign o_r0_err = o_r0_rvalid && r_err;
  assign o_r1_err = o_r1_rvalid && r_err;
  // next state: any memory response or the timeout ends WAIT
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (hs ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? ((i_m_error || i_m_d_valid || tmo) ? RESP : WAIT) :
               IDLE;
  end
  // state, request latch, response capture, timeout counter and priority pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      cnt <= 8'h0;
      l_gnt <= 1'b0;
      l_we <= 1'b0;
      l_sel <= 4'h0;
      l_addr <= 32'h0;
      l_wdata <= 32'h0;
      r_data <= 32'h0;
      r_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        l_gnt <= gnt;
        l_we <= gnt ? i_r1_we : i_r0_we;
        l_sel <= gnt ? i_r1_sel : i_r0_sel;
        l_addr <= gnt ? i_r1_addr : i_r0_addr;
        l_wdata <= gnt ? i_r1_wdata : i_r0_wdata;
      end
      if (state == ISSUE) cnt <= 8'h0;
      if (state == WAIT) begin
        if (i_m_error || (!i_m_d_valid && tmo)) begin
          r_err <= 1'b1;
          r_data <= 32'h0;
        end else if (i_m_d_valid) begin
          r_err <= 1'b0;
          r_data <= i_m_rdata;
        end
        if (!i_m_error && !i_m_d_valid) cnt <= cnt + 8'h1;
      end
      if (resp) prio <= !l_gnt;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 0, rst = 1;
  logic i_r0_valid = 0, i_r1_valid = 0, i_r0_we = 0, i_r1_we = 0;
  logic [3:0] i_r0_sel = 0, i_r1_sel = 0;
  logic [31:0] i_r0_addr = 0, i_r1_addr = 0, i_r0_wdata = 0, i_r1_wdata = 0;
  logic [31:0] i_m_rdata = 0;
  logic i_m_d_valid = 0, i_m_error = 0;
  logic o_r0_ready, o_r1_ready, o_r0_rvalid, o_r1_rvalid, o_r0_err, o_r1_err;
  logic [31:0] o_r0_rdata, o_r1_rdata, o_m_addr, o_m_wdata;
  logic [3:0] o_m_sel;
  logic o_m_wr_en, o_m_d_ready;
  logic [191:0] outs_all;
  int checks = 0, errors = 0, cyc = 0, rv_cnt = 0, rv_cyc = 0, wr_pulses = 0, drdy_cnt = 0;
  typedef struct packed {logic port; logic [31:0] rdata; logic err;} rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  dmem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .i_r0_valid(i_r0_valid), .i_r1_valid(i_r1_valid),
    .o_r0_ready(o_r0_ready), .o_r1_ready(o_r1_ready),
    .i_r0_we(i_r0_we), .i_r0_sel(i_r0_sel), .i_r0_addr(i_r0_addr), .i_r0_wdata(i_r0_wdata),
    .i_r1_we(i_r1_we), .i_r1_sel(i_r1_sel), .i_r1_addr(i_r1_addr), .i_r1_wdata(i_r1_wdata),
    .o_r0_rvalid(o_r0_rvalid), .o_r0_rdata(o_r0_rdata), .o_r0_err(o_r0_err),
    .o_r1_rvalid(o_r1_rvalid), .o_r1_rdata(o_r1_rdata), .o_r1_err(o_r1_err),
    .o_m_wr_en(o_m_wr_en), .o_m_sel(o_m_sel), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata),
    .o_m_d_ready(o_m_d_ready),
    .i_m_rdata(i_m_rdata), .i_m_d_valid(i_m_d_valid), .i_m_error(i_m_error)
  );

  assign outs_all = {52'h0, o_r0_ready, o_r1_ready, o_r0_rvalid, o_r1_rvalid, o_r0_rdata, o_r1_rdata,
                     o_r0_err, o_r1_err, o_m_wr_en, o_m_sel, o_m_addr, o_m_wdata, o_m_d_ready};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(logic p, logic [31:0] d, logic e);
    exp_q.push_back('{p, d, e});
  endtask

  task automatic wait_ready(output logic g, output logic ok);
    g = 0;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (o_r0_ready || o_r1_ready) begin
        ok = 1;
        g = o_r1_ready;
      end else tick();
    end
  endtask

  // response monitor: every rvalid is matched against the scoreboard
  always @(negedge clk) if (!rst) begin
    if (o_m_wr_en) wr_pulses++;
    if (o_m_d_ready) drdy_cnt++;
    if (o_r0_rvalid || o_r1_rvalid) begin
      rv_cnt++;
      rv_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_rvalid", {o_r1_rvalid, o_r0_rvalid}, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp_port", {o_r1_rvalid, o_r0_rvalid}, mon_e.port ? 2'b10 : 2'b01);
        chk("rsp_data", mon_e.port ? o_r1_rdata : o_r0_rdata, mon_e.rdata);
        chk("rsp_err", mon_e.port ? o_r1_err : o_r0_err, mon_e.err);
        chk("rsp_other_side_zero", mon_e.port ? {o_r0_rdata, o_r0_err} : {o_r1_rdata, o_r1_err}, 0);
      end
    end
  end

  initial begin
    logic g, ok;
    int t_hs, n0, d0;
    tick();
    tick();
    chk("reset_outputs", outs_all, 0);
    rst = 0;
    // single read with one-cycle memory latency
    i_r0_valid = 1; i_r0_we = 0; i_r0_sel = 4'hf; i_r0_addr = 32'h100;
    #1;
    chk("t1_ready", {o_r1_ready, o_r0_ready}, 2'b01);
    t_hs = cyc;
    tick();
    i_r0_valid = 0;
    chk("t1_issue", {o_m_d_ready, o_m_wr_en, o_m_sel, o_m_addr}, {1'b1, 1'b0, 4'hf, 32'h100});
    tick();
    i_m_d_valid = 1; i_m_rdata = 32'hCAFEF00D;
    expect_rsp(0, 32'hCAFEF00D, 0);
    tick();
    i_m_d_valid = 0; i_m_rdata = 0;
    tick();
    chk("t1_rvalid_count", rv_cnt, 1);
    chk("t1_latency", rv_cyc - t_hs, 3);
    chk("t1_idle_mem_zero", {o_m_d_ready, o_m_wr_en, o_m_sel, o_m_addr, o_m_wdata}, 0);
    // contention: alternating grants, one write pulse each
    rst = 1;
    tick();
    rst = 0;
    wr_pulses = 0;
    i_r0_valid = 1; i_r0_we = 1; i_r0_sel = 4'h3; i_r0_addr = 32'h10; i_r0_wdata = 32'hA0A0A0A0;
    i_r1_valid = 1; i_r1_we = 1; i_r1_sel = 4'hc; i_r1_addr = 32'h20; i_r1_wdata = 32'hB1B1B1B1;
    for (int i = 0; i < 4; i++) begin
      wait_ready(g, ok);
      chk("t2_handshake_seen", ok, 1);
      chk("t2_grant_order", g, i % 2);
      tick();
      chk("t2_issue_addr", o_m_addr, g ? 32'h20 : 32'h10);
      chk("t2_issue_wdata", o_m_wdata, g ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
      chk("t2_issue_we", o_m_wr_en, 1);
      tick();
      chk("t2_wait_we_low", {o_m_wr_en, o_m_d_ready}, 2'b01);
      i_m_d_valid = 1;
      expect_rsp(g, 0, 0);
      tick();
      i_m_d_valid = 0;
      chk("t2_no_ready_in_resp", {o_r1_ready, o_r0_ready}, 0);
      chk("t2_resp_mem_zero", {o_m_d_ready, o_m_addr}, 0);
      tick();
    end
    i_r0_valid = 0; i_r1_valid = 0;
    chk("t2_wr_pulses", wr_pulses, 4);
    // memory error wins over simultaneous d_valid
    i_r1_valid = 1; i_r1_we = 1; i_r1_addr = 32'h3; i_r1_wdata = 32'h55;
    wait_ready(g, ok);
    chk("t3_grant_r1", {ok, g}, 2'b11);
    tick();
    i_r1_valid = 0;
    chk("t3_issue", {o_m_wr_en, o_m_addr}, {1'b1, 32'h3});
    tick();
    i_m_error = 1; i_m_d_valid = 1; i_m_rdata = 32'hDEADBEEF;
    expect_rsp(1, 0, 1);
    tick();
    i_m_error = 0; i_m_d_valid = 0; i_m_rdata = 0;
    tick();
    // timeout: memory never answers
    i_r0_valid = 1; i_r0_we = 0; i_r0_addr = 32'h200;
    wait_ready(g, ok);
    chk("t4_grant_r0", {ok, g}, 2'b10);
    tick();
    i_r0_valid = 0;
    n0 = rv_cnt;
    d0 = drdy_cnt;
    expect_rsp(0, 0, 1);
    for (int k = 0; k < 40 && rv_cnt == n0; k++) tick();
    chk("t4_rvalid_seen", rv_cnt, n0 + 1);
    chk("t4_wait_cycles", drdy_cnt - d0 - 1, 15);
    i_r0_valid = 1; i_r0_addr = 32'h240;
    #1;
    chk("t4_back_to_idle", {o_r1_ready, o_r0_ready}, 2'b01);
    // reset during WAIT drops the transaction
    tick();
    i_r0_valid = 0;
    tick();
    tick();
    chk("t5_in_wait", o_m_d_ready, 1);
    rst = 1;
    tick();
    chk("t5_outs_zero_in_reset", outs_all, 0);
    rst = 0;
    i_r1_valid = 1; i_r1_we = 0; i_r1_addr = 32'h300;
    #1;
    chk("t5_r1_ready_after_reset", {o_r1_ready, o_r0_ready}, 2'b10);
    tick();
    i_r1_valid = 0;
    tick();
    i_m_d_valid = 1; i_m_rdata = 32'h12345678;
    expect_rsp(1, 32'h12345678, 0);
    tick();
    i_m_d_valid = 0; i_m_rdata = 0;
    tick();
    tick();
    chk("t5_queue_empty", exp_q.size(), 0);
    chk("total_rvalids", rv_cnt, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
